// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types, tuning table and constants for poly_voice_synth
// Contents: wave_t waveform enum, INC_TABLE per-key phase increments for a
// 24-bit accumulator at CLK_HZ, and key_inc() table lookup (0 past the table).
package synth_pkg;

  localparam int CLK_HZ    = 12_000_000;
  localparam int TABLE_LEN = 13;

  typedef enum logic [1:0] {
    SQUARE   = 2'd0,
    SAW      = 2'd1,
    TRIANGLE = 2'd2
  } wave_t;

  // f_note * 2^24 / CLK_HZ, C4 upward in semitones.
  localparam logic [11:0] INC_TABLE [TABLE_LEN] = '{
    12'd366, 12'd388, 12'd411, 12'd435, 12'd461, 12'd488, 12'd517,
    12'd548, 12'd581, 12'd615, 12'd652, 12'd691, 12'd732
  };

  function automatic logic [11:0] key_inc(input logic [3:0] idx);
    return (idx < 4'(TABLE_LEN)) ? INC_TABLE[idx] : 12'd0;
  endfunction

endpackage

// File: rtl/synth_voice.sv
// rtl/synth_voice.sv - one phase-accumulator voice with key register and waveshaper
// Ports: clk, reset (async, active-high); load starts the voice on key_in
// with a cleared accumulator; clr frees the voice and wins over load;
// wave selects the shape; active/key report ownership; sample is the
// shaped 8-bit output (0 while inactive).
module synth_voice
  import synth_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       clr,
  input  logic [3:0] key_in,
  input  wave_t      wave,
  output logic       active,
  output logic [3:0] key,
  output logic [7:0] sample
);

  logic [ACC_W-1:0] acc;
  logic [7:0]       p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= 1'b0;
      key    <= '0;
      acc    <= '0;
    end else if (clr) begin
      active <= 1'b0;
      acc    <= '0;
    end else if (load) begin
      active <= 1'b1;
      key    <= key_in;
      acc    <= '0;
    end else if (active) begin
      acc <= acc + ACC_W'(key_inc(key));
    end
  end

  assign p = acc[ACC_W-1 -: 8];

  always_comb begin
    sample = '0;
    if (active) begin
      case (wave)
        SAW:      sample = p;
        TRIANGLE: sample = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
        default:  sample = p[7] ? 8'hFF : 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/poly_voice_synth.sv
// rtl/poly_voice_synth.sv - polyphonic keypad synth: voice allocation, mixer, mode FSM, PWM
// Ports: clk, reset (async, active-high); en holds the block idle when low;
// keys debounced key levels (bit 0 = C4); mode_edge advances the waveform;
// pwm_o PWM audio; voice_active per-voice busy flags; mode_o current
// waveform; sample_o mixed sample latched once per PWM period.
module poly_voice_synth
  import synth_pkg::*;
#(
  parameter int NUM_KEYS   = 13,
  parameter int NUM_VOICES = 4,
  parameter int ACC_W      = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [NUM_KEYS-1:0]   keys,
  input  logic                  mode_edge,
  output logic                  pwm_o,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [1:0]            mode_o,
  output logic [7:0]            sample_o
);

  localparam int VW = $clog2(NUM_VOICES);

  logic [NUM_KEYS-1:0]   keys_q, pending, pend_nxt, rise, fall, serve_vec;
  logic                  armed;
  logic [VW-1:0]         steal_ptr, free_idx, alloc_idx;
  logic                  any_free, serve_any, alloc_ok;
  logic [3:0]            serve_key;
  logic [NUM_VOICES-1:0] rel, clr, load;
  logic [3:0]            vkey    [NUM_VOICES];
  logic [7:0]            vsample [NUM_VOICES];
  logic [8+VW-1:0]       sum;
  logic [7:0]            pwm_cnt;
  wave_t                 mode;

  // armed masks edges in the first cycle after reset so keys held through
  // reset are absorbed into keys_q instead of looking like fresh presses.
  assign rise      = armed ? (keys & ~keys_q) : '0;
  assign fall      = armed ? (~keys & keys_q) : '0;
  // A key falling this cycle must not be handed a voice it would never release.
  assign serve_vec = pending & ~fall;

  always_comb begin
    serve_any = 1'b0;
    serve_key = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (serve_vec[k]) begin
        serve_any = 1'b1;
        serve_key = 4'(k);
      end
    end

    any_free = 1'b0;
    free_idx = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!voice_active[v]) begin
        any_free = 1'b1;
        free_idx = VW'(v);
      end
    end

    for (int v = 0; v < NUM_VOICES; v++) begin
      rel[v] = 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (fall[k] && vkey[v] == 4'(k)) rel[v] = voice_active[v];
      end
      clr[v] = rel[v] | ~en;
    end

    alloc_idx = any_free ? free_idx : steal_ptr;
    // A release on the target voice wins; pending stays set so it retries.
    alloc_ok  = en & serve_any & ~rel[alloc_idx];
    for (int v = 0; v < NUM_VOICES; v++) begin
      load[v] = alloc_ok && (alloc_idx == VW'(v));
    end

    pend_nxt = (pending | rise) & ~fall;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (alloc_ok && serve_key == 4'(k)) pend_nxt[k] = 1'b0;
    end
  end

  always_comb begin
    sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      sum = sum + (8 + VW)'(vsample[v]);
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    synth_voice #(.ACC_W(ACC_W)) u_voice (
      .clk    (clk),
      .reset  (reset),
      .load   (load[v]),
      .clr    (clr[v]),
      .key_in (serve_key),
      .wave   (mode),
      .active (voice_active[v]),
      .key    (vkey[v]),
      .sample (vsample[v])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keys_q    <= '0;
      armed     <= 1'b0;
      pending   <= '0;
      steal_ptr <= '0;
      mode      <= SQUARE;
      pwm_cnt   <= '0;
      sample_o  <= '0;
      pwm_o     <= 1'b0;
    end else begin
      keys_q  <= keys;
      armed   <= 1'b1;
      pending <= en ? pend_nxt : '0;
      if (alloc_ok && !any_free) steal_ptr <= steal_ptr + VW'(1);
      if (mode_edge) begin
        case (mode)
          SQUARE:  mode <= SAW;
          SAW:     mode <= TRIANGLE;
          default: mode <= SQUARE;
        endcase
      end
      pwm_cnt <= pwm_cnt + 8'd1;
      if (!en)                  sample_o <= '0;
      else if (pwm_cnt == 8'hFF) sample_o <= sum[VW +: 8];
      pwm_o <= en & (pwm_cnt < sample_o);
    end
  end

  assign mode_o = mode;

endmodule
